// File: rtl/tpu_pkg.sv
// Shared constants and state encoding for the TPU sequencer slice.
package tpu_pkg;

    localparam int unsigned BYTE_W     = 8;
    localparam int unsigned PHASE_W    = 4;
    localparam int unsigned N_OPERANDS = 8;
    localparam int unsigned N_RESULTS  = 4;

    localparam logic [1:0] MODE_LOAD_A  = 2'b00;
    localparam logic [1:0] MODE_LOAD_B  = 2'b01;
    localparam logic [1:0] MODE_COMPUTE = 2'b10;
    localparam logic [1:0] MODE_READ    = 2'b11;

    typedef enum logic [2:0] {
        COLLECT,
        LOAD_A,
        LOAD_B,
        COMPUTE,
        READ,
        DRAIN
    } state_e;

endpackage

// File: rtl/tpu_byte_buf.sv
// Small byte register file: one indexed write port, one combinational read port.
module tpu_byte_buf
    import tpu_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    localparam int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [BYTE_W-1:0] wr_data_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [BYTE_W-1:0] rd_data_c_o
);

    logic [BYTE_W-1:0] mem_q [DEPTH];

    // Reset wipes stored bytes so an aborted operation leaves nothing behind.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_c_o = mem_q[rd_idx_i];

endmodule

// File: rtl/tpu_sequencer.sv
// Sequences the TPU core pins: collects 8 operand bytes, runs LOAD_A/LOAD_B/
// COMPUTE/READ bursts with fixed cycle counts, then drains 4 result bytes.
module tpu_sequencer
    import tpu_pkg::*;
#(
    parameter int unsigned COMPUTE_CYCLES = 8,
    parameter int unsigned READ_LAT       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [BYTE_W-1:0] out_data,
    output logic              busy,
    output logic              done,
    output logic [1:0]        tpu_mode,
    output logic [BYTE_W-1:0] tpu_data,
    input  logic [BYTE_W-1:0] tpu_result
);

    localparam logic [PHASE_W-1:0] LAST_LOAD    = PHASE_W'(3);
    localparam logic [PHASE_W-1:0] LAST_COMPUTE = PHASE_W'(COMPUTE_CYCLES - 1);
    localparam logic [PHASE_W-1:0] LAST_READ    = PHASE_W'(READ_LAT + 3);
    localparam logic [PHASE_W-1:0] FIRST_CAP    = PHASE_W'(READ_LAT);

    state_e            state_q;
    logic [PHASE_W-1:0] cnt_q;
    logic [2:0]        idx_q;
    logic [1:0]        ridx_q;
    logic              in_ready_q;
    logic              out_valid_q;
    logic [BYTE_W-1:0] out_data_q;
    logic              busy_q;
    logic              done_q;
    logic [1:0]        mode_q;
    logic [BYTE_W-1:0] data_q;
    logic              cap_en_q;
    logic [1:0]        cap_idx_q;

    logic              in_hs_c;
    logic              out_hs_c;
    logic [2:0]        op_rd_idx_c;
    logic [1:0]        res_rd_idx_c;
    logic [BYTE_W-1:0] op_rd_c;
    logic [BYTE_W-1:0] res_rd_c;

    assign in_hs_c      = in_valid & in_ready_q & (state_q == COLLECT);
    assign out_hs_c     = out_valid_q & out_ready & (state_q == DRAIN);
    assign op_rd_idx_c  = {state_q == LOAD_B, cnt_q[1:0]};
    // Look one entry ahead on a handshake so the next byte is registered without a bubble.
    assign res_rd_idx_c = ridx_q + 2'(out_hs_c);

    tpu_byte_buf #(.DEPTH(N_OPERANDS)) u_op_buf (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (in_hs_c),
        .wr_idx_i    (idx_q),
        .wr_data_i   (in_data),
        .rd_idx_i    (op_rd_idx_c),
        .rd_data_c_o (op_rd_c)
    );

    tpu_byte_buf #(.DEPTH(N_RESULTS)) u_res_buf (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (cap_en_q),
        .wr_idx_i    (cap_idx_q),
        .wr_data_i   (tpu_result),
        .rd_idx_i    (res_rd_idx_c),
        .rd_data_c_o (res_rd_c)
    );

    // Pins are registered decodes of the state, so they trail the state by one cycle;
    // cap_en_q trails the same way and lines up with the READ cycles seen by the core.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            idx_q       <= '0;
            ridx_q      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mode_q      <= MODE_LOAD_A;
            data_q      <= '0;
            cap_en_q    <= 1'b0;
            cap_idx_q   <= '0;
        end else begin
            done_q   <= 1'b0;
            cap_en_q <= 1'b0;
            cnt_q    <= cnt_q + PHASE_W'(1);
            mode_q   <= MODE_LOAD_A;
            data_q   <= '0;
            unique case (state_q)
                COLLECT: begin
                    if (in_hs_c) begin
                        idx_q <= idx_q + 3'd1;
                        if (idx_q == 3'(N_OPERANDS - 1)) begin
                            state_q    <= LOAD_A;
                            cnt_q      <= '0;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                LOAD_A: begin
                    data_q <= op_rd_c;
                    if (cnt_q == LAST_LOAD) begin
                        state_q <= LOAD_B;
                        cnt_q   <= '0;
                    end
                end
                LOAD_B: begin
                    mode_q <= MODE_LOAD_B;
                    data_q <= op_rd_c;
                    if (cnt_q == LAST_LOAD) begin
                        state_q <= COMPUTE;
                        cnt_q   <= '0;
                    end
                end
                COMPUTE: begin
                    mode_q <= MODE_COMPUTE;
                    if (cnt_q == LAST_COMPUTE) begin
                        state_q <= READ;
                        cnt_q   <= '0;
                    end
                end
                READ: begin
                    mode_q <= MODE_READ;
                    if (cnt_q >= FIRST_CAP) begin
                        cap_en_q  <= 1'b1;
                        cap_idx_q <= 2'(cnt_q - FIRST_CAP);
                    end
                    if (cnt_q == LAST_READ) begin
                        state_q <= DRAIN;
                        cnt_q   <= '0;
                    end
                end
                DRAIN: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= res_rd_c;
                    end else if (out_hs_c) begin
                        ridx_q <= ridx_q + 2'd1;
                        if (ridx_q == 2'(N_RESULTS - 1)) begin
                            out_valid_q <= 1'b0;
                            done_q      <= 1'b1;
                            busy_q      <= 1'b0;
                            in_ready_q  <= 1'b1;
                            state_q     <= COLLECT;
                            cnt_q       <= '0;
                        end else begin
                            out_data_q <= res_rd_c;
                        end
                    end
                end
                default: begin
                    state_q <= COLLECT;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign tpu_mode  = mode_q;
    assign tpu_data  = data_q;

endmodule

// File: tb/tb_tpu_sequencer.sv
// Bench for tpu_sequencer: vector table of operations, a 2x2 core model on the
// tpu pins, and a result scoreboard.
module tb_tpu_sequencer;

    localparam int unsigned CC  = 8;
    localparam int unsigned RL  = 1;
    localparam int          LAT = 10 + CC + RL + 4;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
    logic       done;
    logic [1:0] tpu_mode;
    logic [7:0] tpu_data;
    logic [7:0] tpu_result;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb_q[$];

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic        gap;
        logic [7:0]  stall;
        logic        junk;
    } vec_t;

    vec_t vecs[8];

    tpu_sequencer #(.COMPUTE_CYCLES(CC), .READ_LAT(RL)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done),
        .tpu_mode   (tpu_mode),
        .tpu_data   (tpu_data),
        .tpu_result (tpu_result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural 2x2 core: shift-loaded A/B, product on COMPUTE, C streamed on READ.
    logic [7:0] ma[4];
    logic [7:0] mb[4];
    logic [7:0] mc[4];
    logic [3:0] rc;
    always @(posedge clk) begin
        if (rst) begin
            rc         <= '0;
            tpu_result <= 8'hA5;
        end else begin
            tpu_result <= 8'hA5;
            rc         <= '0;
            case (tpu_mode)
                2'b00: begin
                    ma[0] <= ma[1]; ma[1] <= ma[2]; ma[2] <= ma[3]; ma[3] <= tpu_data;
                end
                2'b01: begin
                    mb[0] <= mb[1]; mb[1] <= mb[2]; mb[2] <= mb[3]; mb[3] <= tpu_data;
                end
                2'b10: begin
                    mc[0] <= 8'(ma[0] * mb[0] + ma[1] * mb[2]);
                    mc[1] <= 8'(ma[0] * mb[1] + ma[1] * mb[3]);
                    mc[2] <= 8'(ma[2] * mb[0] + ma[3] * mb[2]);
                    mc[3] <= 8'(ma[2] * mb[1] + ma[3] * mb[3]);
                end
                default: begin
                    rc         <= rc + 4'd1;
                    tpu_result <= (rc < 4'd4) ? mc[rc[1:0]] : 8'h5A;
                end
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
        return w[31 - 8 * i -: 8];
    endfunction

    // Drive the 8 operand bytes; returns at the negedge just after the 8th handshake.
    task automatic feed(input vec_t v);
        for (int i = 0; i < 8; i++) begin
            if (v.gap) begin
                in_valid = 1'b0;
                in_data  = 8'h33;
                @(negedge clk);
                chk("collect_busy", 32'(busy), 32'd0);
            end
            chk("collect_in_ready", 32'(in_ready), 32'd1);
            chk("collect_mode", 32'(tpu_mode), 32'd0);
            in_valid = 1'b1;
            in_data  = (i < 4) ? byte_of(v.a, i) : byte_of(v.b, i - 4);
            @(negedge clk);
        end
        in_valid = v.junk;
        in_data  = 8'hEE;
    endtask

    task automatic finish_op(input vec_t v);
        int         lat;
        bit         ok;
        logic [1:0] em;
        logic [7:0] ed;
        bit         chk_data;
        lat = 0;
        for (int t = 1; t <= 60; t++) begin
            if (out_valid) begin
                lat = t;
                break;
            end
            chk_data = 1'b1;
            ed = 8'd0;
            if (t == 1) em = 2'b00;
            else if (t <= 5) begin em = 2'b00; ed = byte_of(v.a, t - 2); end
            else if (t <= 9) begin em = 2'b01; ed = byte_of(v.b, t - 6); end
            else if (t <= 9 + int'(CC)) em = 2'b10;
            else if (t <= 9 + int'(CC) + int'(RL) + 4) begin em = 2'b11; chk_data = 1'b0; end
            else em = 2'b00;
            chk("trace_mode", 32'(tpu_mode), 32'(em));
            if (chk_data) chk("trace_data", 32'(tpu_data), 32'(ed));
            chk("trace_in_ready", 32'(in_ready), 32'd0);
            chk("trace_busy", 32'(busy), 32'd1);
            chk("trace_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        chk("latency", 32'(lat), 32'(LAT));
        if (lat == 0) begin
            sb_q.delete();
            in_valid = 1'b0;
            return;
        end
        for (int k = 0; k < 4; k++) begin
            int ns;
            ns = (k == 0) ? int'(v.stall) : ((v.stall != 8'd0) ? 1 : 0);
            for (int s = 0; s < ns; s++) begin
                out_ready = 1'b0;
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", 32'(out_data), 32'(sb_q[0]));
                chk("stall_mode", 32'(tpu_mode), 32'd0);
                @(negedge clk);
            end
            out_ready = 1'b1;
            ok = 1'b0;
            for (int w = 0; w < 20; w++) begin
                if (out_valid) begin
                    ok = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            chk("drain_valid", 32'(ok), 32'd1);
            if (!ok) begin
                sb_q.delete();
                out_ready = 1'b0;
                in_valid  = 1'b0;
                return;
            end
            chk("out_data", 32'(out_data), 32'(sb_q.pop_front()));
            chk("drain_mode", 32'(tpu_mode), 32'd0);
            chk("drain_in_ready", 32'(in_ready), 32'd0);
            chk("drain_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("done_pulse", 32'(done), 32'd1);
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("post_busy", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done_single", 32'(done), 32'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic run_op(input vec_t v);
        for (int k = 0; k < 4; k++) sb_q.push_back(byte_of(v.exp, k));
        feed(v);
        finish_op(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0] = '{a: 32'h01020304, b: 32'h05060708, exp: 32'h13162B32, gap: 1'b0, stall: 8'd0,  junk: 1'b0};
        vecs[1] = '{a: 32'h01020304, b: 32'h05060708, exp: 32'h13162B32, gap: 1'b1, stall: 8'd0,  junk: 1'b0};
        vecs[2] = '{a: 32'h01020304, b: 32'h05060708, exp: 32'h13162B32, gap: 1'b0, stall: 8'd10, junk: 1'b0};
        vecs[3] = '{a: 32'h02000002, b: 32'h01010101, exp: 32'h02020202, gap: 1'b0, stall: 8'd0,  junk: 1'b0};
        vecs[4] = '{a: 32'h01020304, b: 32'h01000001, exp: 32'h01020304, gap: 1'b0, stall: 8'd0,  junk: 1'b0};
        vecs[5] = '{a: 32'h01020304, b: 32'h05060708, exp: 32'h13162B32, gap: 1'b0, stall: 8'd2,  junk: 1'b1};
        vecs[6] = '{a: 32'h02000002, b: 32'h01010101, exp: 32'h02020202, gap: 1'b1, stall: 8'd0,  junk: 1'b0};
        vecs[7] = '{a: 32'h01000001, b: 32'h09080706, exp: 32'h09080706, gap: 1'b0, stall: 8'd0,  junk: 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mode", 32'(tpu_mode), 32'd0);
        chk("rst_data", 32'(tpu_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) run_op(vecs[i]);

        // Abort in the middle of COMPUTE, then a fresh operation must be clean.
        feed(vecs[0]);
        in_valid = 1'b0;
        repeat (11) @(negedge clk);
        chk("abort_mode_compute", 32'(tpu_mode), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_mode", 32'(tpu_mode), 32'd0);
        chk("abort_data", 32'(tpu_data), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_idle_mode", 32'(tpu_mode), 32'd0);
            chk("abort_idle_valid", 32'(out_valid), 32'd0);
        end
        run_op(vecs[7]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
